// File: rtl/hpu_core_sequencer.sv
// Sequencer for the HPU core array: broadcasts item indices, aligns exec to the cores'
// two-stage item read, captures accumulators and streams them out. Option: HPU_SEQ_IDX_CHECK_EN.
module hpu_core_sequencer #(
    parameter int NCORE      = 8,
    parameter int LEN_W      = 16,
    parameter int ITEM_DEPTH = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      item_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    output logic                  core_src_v,
    output logic                  core_s_init,
    output logic                  core_exec,
    output logic                  core_update,
    output logic                  core_last_j,
    output logic [31:0]           core_src_data,
    input  logic [NCORE*32-1:0]   core_acc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  idx_err
);

    typedef enum logic [2:0] {CLEAR, IDLE, STREAM, DRAIN, CAPTURE, OUT} state_t;
    localparam int IDX_W = (NCORE > 1) ? $clog2(NCORE) : 1;

    state_t                 state, state_nxt;
    logic [LEN_W-1:0]       len_q, beat_q;
    logic                   clr_to_cap_q;
    logic                   drain_q;
    logic [1:0]             exec_pipe;
    logic [IDX_W-1:0]       out_idx;
    logic [NCORE-1:0][31:0] cap_buf;

    logic        live, hs, m_hs, last_beat, out_last;
    logic [31:0] idx_raw, idx_fwd;
    logic        s_data_unused;

    // Every output is forced low while rst is held, including mid-job.
    assign live          = ~rst;
    assign idx_raw       = {23'd0, s_data[8:0]};
    assign s_data_unused = ^s_data[31:9];

`ifdef HPU_SEQ_IDX_CHECK_EN
    logic idx_bad, err_q;
    assign idx_bad = (idx_raw >= 32'(ITEM_DEPTH));
    assign idx_fwd = idx_bad ? 32'd0 : idx_raw;
    assign idx_err = err_q & live;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (hs && idx_bad)
            err_q <= 1'b1;
    end
`else
    assign idx_fwd = idx_raw;
    assign idx_err = 1'b0;
`endif

    assign s_ready   = live & (state == STREAM);
    assign hs        = s_valid & s_ready;
    assign last_beat = hs & (beat_q == len_q - 1'b1);
    assign out_last  = (out_idx == IDX_W'(NCORE - 1));
    assign m_valid   = live & (state == OUT);
    assign m_hs      = m_valid & m_ready;

    assign core_src_v    = hs;
    assign core_s_init   = hs & (beat_q != '0);
    assign core_src_data = hs ? idx_fwd : 32'd0;
    assign core_exec     = live & exec_pipe[1];
    assign core_update   = live & (state == CAPTURE);
    // Capture and clear share one edge: the buffer takes acc before the clear lands.
    assign core_last_j   = live & ((state == CLEAR) | (state == CAPTURE));
    assign m_data        = m_valid ? cap_buf[out_idx] : 32'd0;
    assign m_last        = m_valid & out_last;
    assign done          = m_hs & out_last;
    assign busy          = live & (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = clr_to_cap_q ? CAPTURE : IDLE;
            IDLE:    if (start) state_nxt = (item_len == '0) ? CLEAR : STREAM;
            STREAM:  if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_q) state_nxt = CAPTURE;
            CAPTURE: state_nxt = OUT;
            OUT:     if (m_hs && out_last) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            len_q        <= '0;
            beat_q       <= '0;
            clr_to_cap_q <= 1'b0;
            drain_q      <= 1'b0;
            exec_pipe    <= '0;
            out_idx      <= '0;
            cap_buf      <= '0;
        end else begin
            state     <= state_nxt;
            exec_pipe <= {exec_pipe[0], core_src_v};
            drain_q   <= (state == DRAIN) ? ~drain_q : 1'b0;

            if (state == IDLE && start) begin
                len_q        <= item_len;
                beat_q       <= '0;
                clr_to_cap_q <= (item_len == '0);
            end else if (state == CLEAR) begin
                clr_to_cap_q <= 1'b0;
            end

            if (hs)
                beat_q <= beat_q + 1'b1;

            if (state == CAPTURE) begin
                cap_buf <= core_acc;
                out_idx <= '0;
            end else if (m_hs) begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

endmodule
